// File: rtl/psc_slot_scheduler_if.sv
// Bundle of the scheduler's handshake/bus signals.
//   master : trigger source side (drives byte_tick, enable, req; observes the slot stream)
//   slave  : scheduler side (observes the inputs, drives the slot stream and status)
// Signals:
//   byte_tick     byte-rate advance strobe
//   enable        allow trigger slots to be granted
//   req           trigger request levels, rising edge = one request
//   tx_addr       current byte index within the slot
//   tx_is_trigger current slot carries a trigger packet
//   tx_chan       channel id of the current trigger slot
//   slot_start    first cycle of a new slot
//   grant         one-hot grant pulse, aligned with slot_start
//   pending       latched outstanding requests
//   drop_cnt      saturating dropped-request count
interface psc_slot_scheduler_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned CHAN_W = 2,
  parameter int unsigned DROP_W = 16
);
  logic              byte_tick;
  logic              enable;
  logic [N_REQ-1:0]  req;
  logic [3:0]        tx_addr;
  logic              tx_is_trigger;
  logic [CHAN_W-1:0] tx_chan;
  logic              slot_start;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  pending;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output byte_tick, enable, req,
    input  tx_addr, tx_is_trigger, tx_chan, slot_start, grant, pending, drop_cnt
  );

  modport slave (
    input  byte_tick, enable, req,
    output tx_addr, tx_is_trigger, tx_chan, slot_start, grant, pending, drop_cnt
  );
endinterface

// File: rtl/psc_slot_scheduler.sv
// Packet-slot scheduler for the shared PSC serial link. Walks the byte index of each
// PKT_LEN-byte slot and, at every slot boundary, decides whether the next slot carries
// a trigger packet (round-robin over latched requests) or an idle packet.
// Ports:
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   sched    psc_slot_scheduler_if.slave: byte_tick/enable/req in; slot stream and
//            status (tx_addr, tx_is_trigger, tx_chan, slot_start, grant, pending,
//            drop_cnt) out
module psc_slot_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned PKT_LEN = 10,
  parameter int unsigned CHAN_W  = 2,
  parameter int unsigned DROP_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  psc_slot_scheduler_if.slave   sched
);

  typedef enum logic [0:0] {StIdleSlot, StTrigSlot} state_e;

  state_e              state_q, state_d;
  logic [3:0]          addr_q, addr_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [CHAN_W-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0]    req_q;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                start_q, start_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic [N_REQ-1:0]    req_edge;
  logic [N_REQ-1:0]    grant_vec;
  logic [CHAN_W-1:0]   winner;
  logic                found;
  logic                boundary;
  logic                take_trig;
  logic                drop_any;
  int unsigned         idx;

  assign req_edge = sched.req & ~req_q;
  assign boundary = sched.byte_tick && (addr_q == 4'(PKT_LEN - 1));

  // First set pending bit at or above rr_q, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_q) + k) % N_REQ;
      if (!found && pending_q[idx]) begin
        found  = 1'b1;
        winner = CHAN_W'(idx);
      end
    end
  end

  assign take_trig = boundary && sched.enable && (|pending_q);
  assign grant_vec = take_trig ? (N_REQ'(1) << winner) : '0;
  // A request edge on an already-pending channel is lost unless that channel is
  // granted this very cycle (then the re-set simply re-arms it).
  assign drop_any  = |(req_edge & pending_q & ~grant_vec);

  always_comb begin
    addr_d    = addr_q;
    state_d   = state_q;
    chan_d    = chan_q;
    rr_d      = rr_q;
    // Set after clear: an edge coinciding with its own grant keeps the bit.
    pending_d = (pending_q & ~grant_vec) | req_edge;
    grant_d   = grant_vec;
    start_d   = boundary;
    drop_d    = drop_q;

    if (sched.byte_tick) begin
      addr_d = (addr_q == 4'(PKT_LEN - 1)) ? 4'd0 : addr_q + 4'd1;
    end

    if (boundary) begin
      if (take_trig) begin
        state_d = StTrigSlot;
        chan_d  = winner;
        rr_d    = CHAN_W'((32'(winner) + 32'd1) % N_REQ);
      end else begin
        state_d = StIdleSlot;
        chan_d  = '0;
      end
    end

    if (drop_any && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdleSlot;
      addr_q    <= '0;
      chan_q    <= '0;
      rr_q      <= '0;
      req_q     <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      start_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      chan_q    <= chan_d;
      rr_q      <= rr_d;
      req_q     <= sched.req;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      drop_q    <= drop_d;
    end
  end

  assign sched.tx_addr       = addr_q;
  assign sched.tx_is_trigger = (state_q == StTrigSlot);
  assign sched.tx_chan       = chan_q;
  assign sched.slot_start    = start_q;
  assign sched.grant         = grant_q;
  assign sched.pending       = pending_q;
  assign sched.drop_cnt      = drop_q;

endmodule

// File: tb/tb_psc_slot_scheduler.sv
// Bench for psc_slot_scheduler. Stimulus pushes expected trigger slots into a queue;
// a monitor checks every slot_start against the queue head (idle slot when empty).
// A second instance with a 2-bit drop counter shares the stimulus to reach saturation.
module tb_psc_slot_scheduler;

  logic clk;
  logic reset;

  psc_slot_scheduler_if #(.N_REQ(4), .CHAN_W(2), .DROP_W(16)) mif ();
  psc_slot_scheduler_if #(.N_REQ(4), .CHAN_W(2), .DROP_W(2))  sif ();

  psc_slot_scheduler #(.N_REQ(4), .PKT_LEN(10), .CHAN_W(2), .DROP_W(16)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .sched   (mif)
  );

  psc_slot_scheduler #(.N_REQ(4), .PKT_LEN(10), .CHAN_W(2), .DROP_W(2)) dut_sat (
    .clk_i   (clk),
    .reset_i (reset),
    .sched   (sif)
  );

  assign sif.byte_tick = mif.byte_tick;
  assign sif.enable    = mif.enable;
  assign sif.req       = mif.req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       trig;
    logic [1:0] chan;
    logic [3:0] grant;
  } slot_t;

  slot_t exp_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;
  int    cyc       = 0;
  int    last_start;
  bit    tick_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Byte strobe: one cycle in every five.
  initial begin
    int tick_cnt;
    tick_cnt = 0;
    mif.byte_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        mif.byte_tick = (tick_cnt == 4);
        tick_cnt = (tick_cnt == 4) ? 0 : tick_cnt + 1;
      end else begin
        mif.byte_tick = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial last_start = -1;
  always @(negedge clk) begin
    slot_t e;
    if (reset) begin
      last_start = -1;
    end else if (mif.slot_start) begin
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("slot_trig", 32'(mif.tx_is_trigger), 32'(e.trig));
      check("slot_chan", 32'(mif.tx_chan), 32'(e.chan));
      check("slot_grant", 32'(mif.grant), 32'(e.grant));
      check("slot_addr0", 32'(mif.tx_addr), 32'd0);
      if (last_start >= 0) check("slot_period", 32'(cyc - last_start), 32'd50);
      last_start = cyc;
    end else if (mif.grant != 4'd0) begin
      check("grant_without_start", 32'(mif.grant), 32'd0);
    end
  end

  function automatic slot_t trig_slot(input logic [1:0] ch);
    slot_t s;
    s.trig  = 1'b1;
    s.chan  = ch;
    s.grant = 4'b0001 << ch;
    return s;
  endfunction

  task automatic wait_addr(input logic [3:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mif.tx_addr == a) ok = 1'b1;
    end
    if (!ok) check("wait_addr_timeout", 32'(mif.tx_addr), 32'(a));
  endtask

  task automatic wait_boundary();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mif.byte_tick && mif.tx_addr == 4'd9) ok = 1'b1;
    end
    if (!ok) check("wait_boundary_timeout", 32'(mif.tx_addr), 32'd9);
  endtask

  task automatic wait_slots(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n * 60 + 100 && seen < n; i++) begin
      @(negedge clk);
      if (!reset && mif.slot_start) seen++;
    end
    if (seen < n) check("wait_slots_timeout", 32'(seen), 32'(n));
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 800 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) check("queue_drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    mif.enable = 1'b1;
    mif.req    = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(mif.tx_addr), 32'd0);
    check("rst_trig", 32'(mif.tx_is_trigger), 32'd0);
    check("rst_chan", 32'(mif.tx_chan), 32'd0);
    check("rst_start", 32'(mif.slot_start), 32'd0);
    check("rst_grant", 32'(mif.grant), 32'd0);
    check("rst_pending", 32'(mif.pending), 32'd0);
    check("rst_drop", 32'(mif.drop_cnt), 32'd0);
    check("rst_drop_sat", 32'(sif.drop_cnt), 32'd0);
    reset   = 1'b0;
    tick_en = 1'b1;

    // Idle slots only, 50-cycle period.
    wait_slots(2);
    wait_addr(4'd7);
    check("addr_walk", 32'(mif.tx_addr), 32'd7);

    // Single request on channel 2.
    wait_addr(4'd3);
    mif.req = 4'b0100;
    exp_q.push_back(trig_slot(2'd2));
    @(negedge clk);
    check("t2_pending", 32'(mif.pending), 32'h4);
    mif.req = 4'b0000;
    wait_empty();
    check("t2_pending_cleared", 32'(mif.pending), 32'h0);
    wait_slots(1);

    // All four together from a fresh rr pointer.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_addr(4'd3);
    mif.req = 4'b1111;
    for (int c = 0; c < 4; c++) exp_q.push_back(trig_slot(2'(c)));
    @(negedge clk);
    check("t3_pending", 32'(mif.pending), 32'hF);
    mif.req = 4'b0000;
    wait_empty();
    wait_slots(1);

    // Repeated pulses on channel 1 while pending: drops counted per cycle.
    wait_addr(4'd2);
    for (int p = 0; p < 3; p++) begin
      mif.req = 4'b0010;
      @(negedge clk);
      mif.req = 4'b0000;
      @(negedge clk);
    end
    exp_q.push_back(trig_slot(2'd1));
    check("t4_drop2", 32'(mif.drop_cnt), 32'd2);
    check("t4_drop2_sat", 32'(sif.drop_cnt), 32'd2);
    check("t4_pending", 32'(mif.pending), 32'h2);
    wait_empty();
    wait_addr(4'd2);
    for (int p = 0; p < 4; p++) begin
      mif.req = 4'b0010;
      @(negedge clk);
      mif.req = 4'b0000;
      @(negedge clk);
    end
    exp_q.push_back(trig_slot(2'd1));
    check("t4_drop5", 32'(mif.drop_cnt), 32'd5);
    check("t4_drop_saturated", 32'(sif.drop_cnt), 32'd3);
    wait_empty();

    // Disabled: request held, idle slots only; enable mid-slot waits for boundary.
    mif.enable = 1'b0;
    wait_addr(4'd2);
    mif.req = 4'b0001;
    wait_slots(2);
    check("t5_pending_held", 32'(mif.pending), 32'h1);
    wait_addr(4'd5);
    mif.enable = 1'b1;
    exp_q.push_back(trig_slot(2'd0));
    mif.req = 4'b0000;
    wait_empty();

    // Edge in the same cycle as its own grant: set wins, no drop.
    wait_addr(4'd3);
    mif.req = 4'b1000;
    @(negedge clk);
    mif.req = 4'b0000;
    exp_q.push_back(trig_slot(2'd3));
    wait_boundary();
    mif.req = 4'b1000;
    exp_q.push_back(trig_slot(2'd3));
    @(negedge clk);
    check("t7_pending_rearmed", 32'(mif.pending), 32'h8);
    check("t7_no_drop", 32'(mif.drop_cnt), 32'd5);
    mif.req = 4'b0000;
    wait_empty();

    // Asynchronous reset in the middle of a trigger slot.
    wait_addr(4'd3);
    mif.req = 4'b0001;
    exp_q.push_back(trig_slot(2'd0));
    wait_slots(1);
    wait_addr(4'd6);
    mif.req = 4'b0011;
    @(negedge clk);
    check("t6_in_trig_slot", 32'(mif.tx_is_trigger), 32'd1);
    check("t6_pending_before", 32'(mif.pending), 32'h2);
    #2;
    reset   = 1'b1;
    mif.req = 4'b0000;
    #1;
    check("t6_addr", 32'(mif.tx_addr), 32'd0);
    check("t6_trig", 32'(mif.tx_is_trigger), 32'd0);
    check("t6_chan", 32'(mif.tx_chan), 32'd0);
    check("t6_grant", 32'(mif.grant), 32'd0);
    check("t6_pending", 32'(mif.pending), 32'd0);
    check("t6_drop", 32'(mif.drop_cnt), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_slots(1);
    check("t6_pending_after", 32'(mif.pending), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
